// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned REG_MSB = 11;
  localparam int unsigned REG_LSB = 8;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  localparam int unsigned MAX_WAIT_DEF = 15;

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Bus between the fetch sequencer and its memory / datapath / PC neighbours.
interface instr_fetch_seq_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               run;
  logic [ADDR_W-1:0]  pc;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               zero_flag;
  logic               carry_flag;
  logic [INSTR_W-1:0] ir;
  logic               exec_en;
  logic               exec_done;
  logic               C3;
  logic               C15;
  logic [ADDR_W-1:0]  jump_instr;
  logic               halted;
  logic               fault;

  modport master (
    input  run, pc, imem_ack, imem_rdata, zero_flag, carry_flag, exec_done,
    output imem_req, imem_addr, ir, exec_en, C3, C15, jump_instr, halted, fault
  );

  modport slave (
    output run, pc, imem_ack, imem_rdata, zero_flag, carry_flag, exec_done,
    input  imem_req, imem_addr, ir, exec_en, C3, C15, jump_instr, halted, fault
  );
endinterface

// File: rtl/instr_fetch_seq_decode.sv
// Combinational opcode classifier for the fetch sequencer.
module seq_decode
  import fetch_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_jump,
  output logic       is_cond,
  output logic       cond_sel,
  output logic       is_halt,
  output logic       is_alu
);

  always_comb begin
    is_jump  = 1'b0;
    is_cond  = 1'b0;
    cond_sel = 1'b0;
    is_halt  = 1'b0;
    is_alu   = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_JMP: is_jump = 1'b1;
      OP_JZ: begin
        is_jump = 1'b1;
        is_cond = 1'b1;
      end
      // cond_sel picks carry over zero
      OP_JC: begin
        is_jump  = 1'b1;
        is_cond  = 1'b1;
        cond_sel = 1'b1;
      end
      OP_HLT:  is_halt = 1'b1;
      default: is_alu  = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch/decode/execute sequencer issuing one PC-update pulse (C3 load / C15 increment) per instruction.
module instr_fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  instr_fetch_seq_if.master bus
);

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t             state;
  logic [INSTR_W-1:0] ir_q;
  logic [3:0]         wait_cnt;
  logic               fault_q;
  logic               c3_q;
  logic               c15_q;

  logic is_jump, is_cond, cond_sel, is_halt, is_alu;
  logic take_load;

  seq_decode u_decode (
    .opcode   (ir_q[OPC_MSB:OPC_LSB]),
    .is_jump  (is_jump),
    .is_cond  (is_cond),
    .cond_sel (cond_sel),
    .is_halt  (is_halt),
    .is_alu   (is_alu)
  );

  always_comb begin
    take_load = is_jump & (~is_cond | (cond_sel ? bus.carry_flag : bus.zero_flag));
  end

  // Pulses are registered on the transition into UPDATE so they are glitch-free for a whole cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ir_q     <= '0;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
      c3_q     <= 1'b0;
      c15_q    <= 1'b0;
    end else begin
      c3_q     <= 1'b0;
      c15_q    <= 1'b0;
      wait_cnt <= '0;
      case (state)
        ST_IDLE: if (bus.run) state <= ST_FETCH;
        ST_FETCH: begin
          if (bus.imem_ack) begin
            ir_q  <= bus.imem_rdata;
            state <= ST_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            fault_q <= 1'b1;
            state   <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_DECODE: begin
          if (is_halt) begin
            state <= ST_HALT;
          end else if (is_alu) begin
            state <= ST_EXEC;
          end else begin
            state <= ST_UPDATE;
            c3_q  <= take_load;
            c15_q <= ~take_load;
          end
        end
        ST_EXEC: begin
          if (bus.exec_done) begin
            state <= ST_UPDATE;
            c15_q <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            fault_q <= 1'b1;
            state   <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_UPDATE: state <= bus.run ? ST_FETCH : ST_IDLE;
        ST_HALT:   ;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.imem_req   = (state == ST_FETCH);
    bus.imem_addr  = (state == ST_FETCH) ? bus.pc : '0;
    bus.exec_en    = (state == ST_EXEC);
    bus.halted     = (state == ST_HALT);
    bus.ir         = ir_q;
    bus.jump_instr = ADDR_W'(ir_q[IMM_MSB:IMM_LSB]);
    bus.C3         = c3_q;
    bus.C15        = c15_q;
    bus.fault      = fault_q;
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq: directed ROM programs, PC/memory/datapath models, event monitor.
module tb_instr_fetch_seq;
  import fetch_seq_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 16;

  typedef enum logic [1:0] {EV_FETCH, EV_INC, EV_LOAD, EV_EXEC} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int unsigned val;
    int unsigned gap;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_seq_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  instr_fetch_seq #(.ADDR_W(AW), .INSTR_W(IW), .MAX_WAIT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [IW-1:0] rom [256];
  logic [AW-1:0] pc_init = '0;
  int unsigned   ack_wait = 0;
  int unsigned   exec_lat = 1;
  int unsigned   f_ctr, e_ctr;
  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   cyc = 0;
  int unsigned   last_pulse = 0;
  int unsigned   ex_cnt = 0;
  logic          ex_prev = 1'b0;
  ev_t           sbq[$];

  // Memory and datapath responders
  assign bus.imem_rdata = rom[bus.imem_addr];
  assign bus.imem_ack   = bus.imem_req && (f_ctr >= ack_wait);
  assign bus.exec_done  = bus.exec_en && (e_ctr + 1 >= exec_lat);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_ctr <= 0;
      e_ctr <= 0;
    end else begin
      f_ctr <= (bus.imem_req && !bus.imem_ack) ? f_ctr + 1 : 0;
      e_ctr <= (bus.exec_en && !bus.exec_done) ? e_ctr + 1 : 0;
    end
  end

  // PC register samples the pulses on the falling edge
  always @(negedge clk or negedge rst) begin
    if (!rst)         bus.pc <= pc_init;
    else if (bus.C3)  bus.pc <= bus.jump_instr;
    else if (bus.C15) bus.pc <= bus.pc + 8'd1;
  end

  task automatic push(input ev_kind_t k, input int unsigned v, input int unsigned g);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.gap  = g;
    sbq.push_back(e);
  endtask

  task automatic sb_check(input ev_kind_t k, input int unsigned v);
    ev_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got %s val=%0h, required no event", k.name(), v);
      return;
    end
    e = sbq.pop_front();
    if (e.kind != k || e.val != v) begin
      errors++;
      $display("FAIL sb_%s: got %s val=%0h, required %s val=%0h",
               e.kind.name(), k.name(), v, e.kind.name(), e.val);
    end else if (e.gap != 0 && (cyc - last_pulse) != e.gap) begin
      errors++;
      $display("FAIL sb_gap: got %0d cycles between pulses, required %0d", cyc - last_pulse, e.gap);
    end
    if (k == EV_INC || k == EV_LOAD) last_pulse = cyc;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      ex_prev = 1'b0;
      ex_cnt  = 0;
    end else begin
      if (bus.C3 || bus.C15) begin
        checks++;
        if (bus.C3 && bus.C15) begin
          errors++;
          $display("FAIL pulse_excl: C3=%0b C15=%0b, required one-hot", bus.C3, bus.C15);
        end
      end
      if (bus.imem_req && bus.imem_ack) sb_check(EV_FETCH, int'(bus.imem_addr));
      if (bus.exec_en) begin
        ex_cnt++;
      end else if (ex_prev) begin
        sb_check(EV_EXEC, ex_cnt);
        ex_cnt = 0;
      end
      ex_prev = bus.exec_en;
      if (bus.C3)       sb_check(EV_LOAD, int'(bus.jump_instr));
      else if (bus.C15) sb_check(EV_INC, 0);
    end
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [AW-1:0] p);
    rst     = 1'b0;
    pc_init = p;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_q(input int unsigned n, input int unsigned maxc, input string nm);
    for (int i = 0; i < maxc && sbq.size() > n; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (sbq.size() > n) begin
      errors++;
      $display("FAIL %s: %0d events pending, required <= %0d", nm, sbq.size(), n);
      sbq.delete();
    end
  endtask

  // Let the program run until n events remain, drop run, drain, confirm idle
  task automatic finish_prog(input int unsigned n, input string nm);
    wait_q(n, 80, {nm, "_progress"});
    bus.run = 1'b0;
    wait_q(0, 80, {nm, "_drain"});
    repeat (4) @(negedge clk);
    #1 chk({nm, "_idle_req"}, bus.imem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[8'h05] = 16'h8020;
    rom[8'h10] = 16'h9040;
    rom[8'h11] = 16'h9040;
    rom[8'h40] = 16'hA060;
    rom[8'h30] = 16'h3123;
    rom[8'h31] = 16'h3000;
    rom[8'h70] = 16'hF000;
    bus.run        = 1'b0;
    bus.zero_flag  = 1'b0;
    bus.carry_flag = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_outputs", {bus.exec_en, bus.C3, bus.C15, bus.halted, bus.fault}, 0);
    chk("rst_ir", bus.ir, 0);
    chk("rst_jump_instr", bus.jump_instr, 0);

    // 1: straight-line NOPs, zero-wait fetch, pulse every 3 cycles
    bus.run = 1'b1;
    push(EV_FETCH, 8'h00, 0); push(EV_INC, 0, 0);
    push(EV_FETCH, 8'h01, 0); push(EV_INC, 0, 3);
    push(EV_FETCH, 8'h02, 0); push(EV_INC, 0, 3);
    do_reset(8'h00);
    finish_prog(1, "nop_seq");

    // 2: unconditional jump
    bus.run = 1'b1;
    push(EV_FETCH, 8'h05, 0); push(EV_LOAD, 8'h20, 0);
    push(EV_FETCH, 8'h20, 0); push(EV_INC, 0, 3);
    do_reset(8'h05);
    finish_prog(1, "jmp");

    // 3: JZ not taken (carry set as decoy), JZ taken, JC taken
    bus.run = 1'b1;
    bus.carry_flag = 1'b1;
    push(EV_FETCH, 8'h10, 0); push(EV_INC, 0, 0);
    push(EV_FETCH, 8'h11, 0); push(EV_LOAD, 8'h40, 3);
    push(EV_FETCH, 8'h40, 0); push(EV_LOAD, 8'h60, 3);
    push(EV_FETCH, 8'h60, 0); push(EV_INC, 0, 3);
    do_reset(8'h10);
    wait_q(6, 40, "jz_first");
    bus.zero_flag = 1'b1;
    finish_prog(1, "cond");
    bus.zero_flag  = 1'b0;
    bus.carry_flag = 1'b0;

    // 4: two ALU ops, execute takes 4 cycles each
    bus.run  = 1'b1;
    exec_lat = 4;
    push(EV_FETCH, 8'h30, 0); push(EV_EXEC, 4, 0); push(EV_INC, 0, 0);
    push(EV_FETCH, 8'h31, 0); push(EV_EXEC, 4, 0); push(EV_INC, 0, 7);
    do_reset(8'h30);
    finish_prog(2, "alu");
    chk("alu_fault", bus.fault, 0);

    // 5: fetch never acknowledged -> timeout fault
    begin
      int unsigned req_cycles = 0;
      bus.run  = 1'b1;
      ack_wait = 1000;
      do_reset(8'h50);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.imem_req) req_cycles++;
        else if (req_cycles > 0) break;
      end
      #1;
      chk("timeout_req_cycles", req_cycles, 15);
      chk("timeout_fault", bus.fault, 1);
      chk("timeout_halted", bus.halted, 1);
      chk("timeout_req_dropped", bus.imem_req, 0);
      repeat (10) @(negedge clk);
      #1;
      chk("timeout_sticky", {bus.fault, bus.halted, bus.imem_req}, 3'b110);
      ack_wait = 0;
    end

    // 6: asynchronous reset during EXEC, then restart at same pc
    begin
      int unsigned n_ex = 0;
      bus.run  = 1'b1;
      exec_lat = 10;
      push(EV_FETCH, 8'h30, 0);
      do_reset(8'h30);
      for (int i = 0; i < 30 && n_ex < 3; i++) begin
        @(negedge clk);
        if (bus.exec_en) n_ex++;
      end
      chk("mid_exec_seen", n_ex, 3);
      #1 rst = 1'b0;
      #1;
      chk("async_exec_en", bus.exec_en, 0);
      chk("async_pulses", {bus.imem_req, bus.C3, bus.C15}, 0);
      chk("async_ir", bus.ir, 0);
      chk("async_status", {bus.halted, bus.fault, bus.jump_instr}, 0);
      chk("async_sb_empty", sbq.size(), 0);
      exec_lat = 3;
      push(EV_FETCH, 8'h30, 0); push(EV_EXEC, 3, 0); push(EV_INC, 0, 0);
      push(EV_FETCH, 8'h31, 0); push(EV_EXEC, 3, 0); push(EV_INC, 0, 6);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      finish_prog(2, "restart");
    end

    // HLT: one fetch, then nothing until reset
    bus.run = 1'b1;
    push(EV_FETCH, 8'h70, 0);
    do_reset(8'h70);
    wait_q(0, 20, "hlt_fetch");
    repeat (3) @(negedge clk);
    #1;
    chk("hlt_halted", bus.halted, 1);
    chk("hlt_quiet", {bus.imem_req, bus.exec_en, bus.C3, bus.C15, bus.fault}, 0);
    repeat (10) @(negedge clk);
    #1 chk("hlt_stays", {bus.halted, bus.imem_req}, 2'b10);

    chk("sb_final_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
